seq_detect_prog: RTL
====================

Name: seq_detect_prog

Overview:
- Runtime-programmable serial sequence detector; successor to the fixed-pattern detector FSMs in the serial protocol front-end.
- Pattern, pattern length (1..MAX_LEN) and overlap/non-overlap mode are loaded through a config strobe.
- Qualified serial bit stream in; one-cycle registered detect pulse and saturating match counter out.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width
LEN_W, $clog2(MAX_LEN)+1, width of cfg_len (derived; do not override)
TIMEOUT, 16, idle-cycle limit; used only with SEQ_TIMEOUT_EN

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted at 0)
cfg_load  input  1  latch cfg_pattern/cfg_len/cfg_overlap this cycle
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is first bit received, bit [0] is last
cfg_len  input  LEN_W  pattern length
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
in_valid  input  1  in_bit is valid this cycle
in_bit  input  1  serial data bit
cnt_clr  input  1  synchronous clear of match_count
detected  output  1  one-cycle pulse, registered
match_count  output  CNT_W  saturating count of detections
armed  output  1  1 when config is valid (len != 0)

Behaviour:
- Reset (rst=0, async): pattern=0, len=0, overlap=0, history=0, fill=0, detected=0, match_count=0, armed=0. Detector is disabled until the first cfg_load.
- Config: on cfg_load, pattern, len and overlap are registered; history and fill are cleared; in_bit is ignored that cycle; detected=0 on the next cycle.
- Length clamping: cfg_len > MAX_LEN is stored as MAX_LEN. cfg_len == 0 is stored as 0, which disables detection (armed=0).
- State (derived): DISABLED (len==0), FILL (fill<len), ARMED_CMP (fill>=len).
- Accepted bit (in_valid=1, cfg_load=0):
  - history <= {history[MAX_LEN-2:0], in_bit}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on the post-shift history: state not DISABLED, fill_next >= len, and history_next[len-1:0] == pattern[len-1:0].
- On a match:
  - detected=1 on the following cycle, for exactly one cycle.
  - match_count increments and saturates at 2^CNT_W-1.
  - Overlap=1: fill is kept, so a suffix of the matched bits can start the next match.
  - Overlap=0: fill <= 0 on the same edge, so bits of one match are never reused.
- in_valid=0: no shift, no fill change; detected=0 on the next cycle. Bubbles are transparent to matching.
- Latency: exactly 1 clock from the accepting edge of the last pattern bit to detected high.
- cnt_clr, priority:
  - cnt_clr and a match on the same edge: match_count = 1.
  - cnt_clr alone: match_count = 0.
  - cnt_clr does not affect history or detection.
- cfg_load and in_valid on the same cycle: cfg_load wins, and the bit is dropped.
- Reset mid-stream discards all partial progress and all config.

Optional Feature:
SEQ_TIMEOUT_EN
- Defined: an idle counter counts consecutive cycles with in_valid=0 and clears on every accepted bit or cfg_load. When it reaches TIMEOUT, fill is cleared (history is flushed) and the counter holds until the next accepted bit. Partial sequences separated by TIMEOUT or more idle cycles cannot match.
- Undefined: no idle counter; gaps of any length are transparent.

Test Plan:
- Load pattern=8'b0000_1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 (in_valid=1) -> detected pulses 1 cycle after bits 4 and 7; match_count=2.
- Load pattern=3'b111, len=3, overlap=0; stream 1,1,1,1,1 -> single pulse after bit 3; match_count=1. Same with overlap=1 -> pulses after bits 3, 4 and 5; match_count=3.
- Pattern 1011, len=4; stream 1,0,1,1 with 3-cycle in_valid=0 gaps between bits -> one pulse after the last accepted bit; no pulse during gaps.
- CNT_W=2, pattern 1 with len=1: 5 accepted 1s -> match_count saturates at 3. Then cnt_clr together with a matching bit -> match_count=1.
- After 1,0,1 of pattern 1011, pulse rst=0 for 1 cycle, then send 1 -> no detect; armed=0; match_count=0. cfg_len=0 load -> never detects. cfg_len=15 -> behaves as len=8.
- SEQ_TIMEOUT_EN, TIMEOUT=4: send 1,0,1, idle 4 cycles, then 1 -> no detect. Same with idle 3 cycles -> detect.

Source files
------------

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial sequence detector.
// A pattern of 1..MAX_LEN bits, its length and the overlap mode are loaded
// through cfg_load. Accepted bits shift into a history register. A match
// produces a one-cycle registered pulse and bumps a saturating counter.
// Optional macro SEQ_TIMEOUT_EN: TIMEOUT consecutive idle cycles flush the
// partial sequence, so bits separated by a long gap can never match.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cnt_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  localparam logic [LEN_W-1:0] MaxLenV = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    DISABLED,
    FILL,
    ARMED_CMP
  } state_e;

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               overlap_q, overlap_d;
  logic               detected_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               match;
  state_e             state_s;

`ifdef SEQ_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IdleMax = IDLE_W'(TIMEOUT);
  logic [IDLE_W-1:0] idle_q, idle_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Derive the detector state from the stored length and the fill level.
  always_comb begin
    state_s = DISABLED;
    if (len_q == '0) begin
      state_s = DISABLED;
    end else if (fill_q < len_q) begin
      state_s = FILL;
    end else begin
      state_s = ARMED_CMP;
    end
  end

  // Mask selecting the low len_q bits of history and pattern for the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  // Next-state logic: config load, bit shifting, matching and the counter.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    count_d   = count_q;
    match     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    idle_d    = idle_q;
`endif
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = (cfg_len > MaxLenV) ? MaxLenV : cfg_len;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
`ifdef SEQ_TIMEOUT_EN
      idle_d    = '0;
`endif
    end else if (in_valid) begin
      hist_d = {hist_q[MAX_LEN-2:0], in_bit};
      fill_d = (fill_q >= MaxLenV) ? MaxLenV : fill_q + LEN_W'(1);
      if ((state_s != DISABLED) && (fill_d >= len_q) &&
          (((hist_d ^ pattern_q) & len_mask) == '0)) begin
        match = 1'b1;
        if (!overlap_q) begin
          fill_d = '0;
        end
      end
`ifdef SEQ_TIMEOUT_EN
      idle_d = '0;
`endif
    end else begin
`ifdef SEQ_TIMEOUT_EN
      if (idle_q != IdleMax) begin
        idle_d = idle_q + IDLE_W'(1);
      end
      if (idle_d == IdleMax) begin
        fill_d = '0;
        hist_d = '0;
      end
`endif
    end
    if (cnt_clr) begin
      count_d = match ? CNT_W'(1) : '0;
    end else if (match && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q  <= '0;
      len_q      <= '0;
      overlap_q  <= 1'b0;
      hist_q     <= '0;
      fill_q     <= '0;
      detected_q <= 1'b0;
      count_q    <= '0;
`ifdef SEQ_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      pattern_q  <= pattern_d;
      len_q      <= len_d;
      overlap_q  <= overlap_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      detected_q <= match;
      count_q    <= count_d;
`ifdef SEQ_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign detected    = detected_q;
  assign match_count = count_q;
  assign armed       = (len_q != '0);

endmodule
